// File: rtl/packet_executor_if.sv
// Memory and control bus between the packet executor (master) and the width/byte-select
// adaptor plus its controller (slave).
interface packet_executor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_width;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              exec_done;

  modport master (
    input  start, start_addr, mem_rdata,
    output mem_ce, mem_we, mem_addr, mem_width, mem_wdata, exec_done
  );

  modport slave (
    output start, start_addr, mem_rdata,
    input  mem_ce, mem_we, mem_addr, mem_width, mem_wdata, exec_done
  );
endinterface

// File: rtl/packet_executor.sv
// Micro-sequencer: fetches 32-bit action words and runs them over the packet buffer.
// Optional instruction watchdog enabled by defining EXEC_WATCHDOG_EN.
module packet_executor #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_STEPS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  packet_executor_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StFwait, StExec, StMreq, StMwait, StDone
  } state_e;

  localparam logic [3:0] OpHalt = 4'd0;
  localparam logic [3:0] OpLi   = 4'd1;
  localparam logic [3:0] OpAddi = 4'd2;
  localparam logic [3:0] OpLd   = 4'd3;
  localparam logic [3:0] OpSt   = 4'd4;
  localparam logic [3:0] OpBnez = 4'd5;
  localparam logic [3:0] OpAdd  = 4'd6;

  if (MAX_STEPS == 0) begin : g_bad_max_steps
    $error("MAX_STEPS must be nonzero");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [25:0]       instr_q, instr_d;  // bits [21:16] of the word are never used
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];

  logic [3:0]  op;
  logic [1:0]  rd, rt, wc;
  logic [15:0] imm;
  assign {op, rd, rt, wc, imm} = instr_q;

  logic [ADDR_W-1:0] pc_inc, br_target, ea;
  logic [DATA_W-1:0] imm_sext, st_mask;
  logic [3:0]        acc_width;
  logic              illegal;
  logic              wd_hit;

  assign pc_inc    = pc_q + ADDR_W'(4);
  assign br_target = pc_inc + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  assign ea        = ADDR_W'(regs_q[rt]) + ADDR_W'(imm);
  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign illegal   = (op > OpAdd) || (((op == OpLd) || (op == OpSt)) && (wc == 2'b11));

  always_comb begin
    acc_width = 4'd4;
    st_mask   = '1;
    unique case (wc)
      2'b00: begin
        acc_width = 4'd1;
        st_mask   = DATA_W'(8'hFF);
      end
      2'b01: begin
        acc_width = 4'd2;
        st_mask   = DATA_W'(16'hFFFF);
      end
      default: ;
    endcase
  end

`ifdef EXEC_WATCHDOG_EN
  logic [31:0] step_q, step_d;

  // Fires on the MAX_STEPS-th EXEC cycle of a run.
  assign wd_hit = (step_q >= 32'(MAX_STEPS - 1));

  always_comb begin
    step_d = step_q;
    if (state_q == StIdle && bus.start) begin
      step_d = '0;
    end else if (state_q == StExec) begin
      step_d = step_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    regs_d        = regs_q;
    bus.mem_ce    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_width = '0;
    bus.mem_wdata = '0;
    bus.exec_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          state_d = StFetch;
        end
      end
      StFetch: begin
        bus.mem_ce    = 1'b1;
        bus.mem_addr  = pc_q;
        bus.mem_width = 4'd4;
        state_d       = StFwait;
      end
      StFwait: begin
        instr_d = {bus.mem_rdata[31:22], bus.mem_rdata[15:0]};
        state_d = StExec;
      end
      StExec: begin
        // A watchdog hit abandons the current instruction entirely.
        if (wd_hit || illegal || (op == OpHalt)) begin
          state_d = StDone;
        end else begin
          pc_d    = pc_inc;
          state_d = StFetch;
          case (op)
            OpLi:       regs_d[rd] = DATA_W'(imm);
            OpAddi:     regs_d[rd] = regs_q[rd] + imm_sext;
            OpLd, OpSt: state_d = StMreq;
            OpBnez:     if (regs_q[rd] != '0) pc_d = br_target;
            OpAdd:      regs_d[rd] = regs_q[rd] + regs_q[rt];
            default:    ;
          endcase
        end
      end
      StMreq: begin
        bus.mem_ce    = 1'b1;
        bus.mem_we    = (op == OpSt);
        bus.mem_addr  = ea;
        bus.mem_width = acc_width;
        if (op == OpSt) begin
          bus.mem_wdata = regs_q[rd] & st_mask;
          state_d       = StFetch;
        end else begin
          state_d = StMwait;
        end
      end
      StMwait: begin
        regs_d[rd] = bus.mem_rdata;
        state_d    = StFetch;
      end
      StDone: begin
        bus.exec_done = 1'b1;
        if (!bus.start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_packet_executor.sv
// Scoreboard bench for packet_executor: expected memory accesses are queued by the stimulus
// and checked by an independent monitor; big-endian byte memory behind the port.
module tb_packet_executor;

`ifdef EXEC_WATCHDOG_EN
  localparam int unsigned WdSteps = 16;
`else
  localparam int unsigned WdSteps = 1024;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
  } acc_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  acc_t exp_q[$];

  packet_executor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  packet_executor #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_STEPS(WdSteps)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory; preload goes through the same process as DUT writes.
  logic [7:0] mem [0:1023];
  logic       pre_we;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;
  logic [9:0] a0, a1, a2, a3;
  assign a0 = bus.mem_addr[9:0];
  assign a1 = a0 + 10'd1;
  assign a2 = a0 + 10'd2;
  assign a3 = a0 + 10'd3;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_ce && bus.mem_we) begin
      case (bus.mem_width)
        4'd1: mem[a0] <= bus.mem_wdata[7:0];
        4'd2: begin
          mem[a0] <= bus.mem_wdata[15:8];
          mem[a1] <= bus.mem_wdata[7:0];
        end
        default: begin
          mem[a0] <= bus.mem_wdata[31:24];
          mem[a1] <= bus.mem_wdata[23:16];
          mem[a2] <= bus.mem_wdata[15:8];
          mem[a3] <= bus.mem_wdata[7:0];
        end
      endcase
    end else if (bus.mem_ce) begin
      case (bus.mem_width)
        4'd1:    bus.mem_rdata <= {24'd0, mem[a0]};
        4'd2:    bus.mem_rdata <= {16'd0, mem[a0], mem[a1]};
        default: bus.mem_rdata <= {mem[a0], mem[a1], mem[a2], mem[a3]};
      endcase
    end
  end

  // Monitor: every enabled access must match the head of the queue; idle port must be zero.
  acc_t got, want;
  always @(negedge clk) begin
    if (!rst) begin
      got = '{bus.mem_we, bus.mem_addr, bus.mem_width, bus.mem_wdata};
      checks++;
      if (bus.mem_ce) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL access_unexpected: got we=%0b addr=%0h width=%0d data=%0h, want none",
                   got.we, got.addr, got.width, got.data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL access: got we=%0b addr=%0h width=%0d data=%0h, want we=%0b addr=%0h width=%0d data=%0h",
                     got.we, got.addr, got.width, got.data,
                     want.we, want.addr, want.width, want.data);
          end
        end
      end else if (got !== '0) begin
        errors++;
        $display("FAIL idle_port_zero: got we=%0b addr=%0h width=%0d data=%0h, want all 0",
                 got.we, got.addr, got.width, got.data);
      end
    end
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rt, input logic [1:0] wc,
                                      input logic [15:0] imm);
    return {op, rd, rt, wc, 6'd0, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] want_v);
    checks++;
    if (got_v !== want_v) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got_v, want_v);
    end
  endtask

  task automatic put_byte(input logic [9:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic put_word(input logic [9:0] a, input logic [31:0] w);
    put_byte(a, w[31:24]);
    put_byte(a + 10'd1, w[23:16]);
    put_byte(a + 10'd2, w[15:8]);
    put_byte(a + 10'd3, w[7:0]);
  endtask

  task automatic exp_acc(input logic we, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d);
    acc_t e;
    e = '{we, a, w, d};
    exp_q.push_back(e);
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    exp_acc(1'b0, a, 4'd4, 32'd0);
  endtask

  // Start a run, count cycles from the accept edge to exec_done, then release start.
  task automatic run(input string name, input logic [31:0] addr, input int exp_cycles);
    int n;
    n = 0;
    bus.start      = 1'b1;
    bus.start_addr = addr;
    @(posedge clk);
    #1 bus.start_addr = 32'h0000_03F0;  // must not be resampled mid-run
    while (n < 3000) begin
      @(negedge clk);
      if (bus.exec_done) break;
      @(posedge clk);
      n++;
    end
    chk({name, "_latency"}, n, exp_cycles);
    @(posedge clk);
    #1 chk({name, "_done_held"}, {31'd0, bus.exec_done}, 32'd1);
    bus.start = 1'b0;
    @(posedge clk);
    #1 chk({name, "_done_drop"}, {31'd0, bus.exec_done}, 32'd0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    pre_we         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;
    bus.start      = 1'b1;
    bus.start_addr = 32'd64;
    @(posedge clk);
    #1;
    put_word(10'd64, 32'h0000_0000);

    // Reset held with start high: all outputs stay 0.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ce", {31'd0, bus.mem_ce}, 32'd0);
      chk("rst_done", {31'd0, bus.exec_done}, 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_we_width", {27'd0, bus.mem_we, bus.mem_width}, 32'd0);
    end

    // Lone HALT: single fetch, done three cycles after accept.
    exp_fetch(32'd64);
    rst = 1'b0;
    run("halt", 32'd64, 3);

    // LI r1,0xAB; ST r1,[r0+4] 1B; HALT.
    put_word(10'd64, enc(4'd1, 2'd1, 2'd0, 2'd0, 16'h00AB));
    put_word(10'd68, enc(4'd4, 2'd1, 2'd0, 2'd0, 16'h0004));
    put_word(10'd72, 32'h0000_0000);
    exp_fetch(32'd64);
    exp_fetch(32'd68);
    exp_acc(1'b1, 32'd4, 4'd1, 32'h0000_00AB);
    exp_fetch(32'd72);
    run("st_byte", 32'd64, 3 + 4 + 3);
    chk("st_byte_mem4", {24'd0, mem[4]}, 32'hAB);

    // LD r2,[r0+0] 2B; ST r2,[r0+8] 4B; HALT.
    put_byte(10'd0, 8'h12);
    put_byte(10'd1, 8'h34);
    put_word(10'd64, enc(4'd3, 2'd2, 2'd0, 2'd1, 16'h0000));
    put_word(10'd68, enc(4'd4, 2'd2, 2'd0, 2'd2, 16'h0008));
    exp_fetch(32'd64);
    exp_acc(1'b0, 32'd0, 4'd2, 32'd0);
    exp_fetch(32'd68);
    exp_acc(1'b1, 32'd8, 4'd4, 32'h0000_1234);
    exp_fetch(32'd72);
    run("ld_st", 32'd64, 5 + 4 + 3);
    chk("ld_st_mem8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'h0000_1234);

    // LI r0,3; ADDI r0,-1; BNEZ r0,-2; HALT: eight instructions at three cycles each.
    put_word(10'd64, enc(4'd1, 2'd0, 2'd0, 2'd0, 16'h0003));
    put_word(10'd68, enc(4'd2, 2'd0, 2'd0, 2'd0, 16'hFFFF));
    put_word(10'd72, enc(4'd5, 2'd0, 2'd0, 2'd0, 16'hFFFE));
    put_word(10'd76, 32'h0000_0000);
    exp_fetch(32'd64);
    for (int i = 0; i < 3; i++) begin
      exp_fetch(32'd68);
      exp_fetch(32'd72);
    end
    exp_fetch(32'd76);
    run("loop", 32'd64, 24);

    // Registers survive across runs: r0=0, r1=0xAB, r2=0x1234.
    put_word(10'd128, enc(4'd4, 2'd0, 2'd1, 2'd2, 16'h0055));
    put_word(10'd132, enc(4'd4, 2'd2, 2'd1, 2'd1, 16'h0059));
    put_word(10'd136, 32'h0000_0000);
    exp_fetch(32'd128);
    exp_acc(1'b1, 32'h100, 4'd4, 32'd0);
    exp_fetch(32'd132);
    exp_acc(1'b1, 32'h104, 4'd2, 32'h0000_1234);
    exp_fetch(32'd136);
    run("persist", 32'd128, 4 + 4 + 3);
    chk("persist_mem104", {16'd0, mem[10'h104], mem[10'h105]}, 32'h1234);

    // LI r1,1; BNEZ r1,-1 spins forever.
    put_word(10'd192, enc(4'd1, 2'd1, 2'd0, 2'd0, 16'h0001));
    put_word(10'd196, enc(4'd5, 2'd1, 2'd0, 2'd0, 16'hFFFF));
    exp_fetch(32'd192);
`ifdef EXEC_WATCHDOG_EN
    for (int i = 0; i < 15; i++) exp_fetch(32'd196);
    run("watchdog", 32'd192, 48);
`else
    for (int i = 0; i < 800; i++) exp_fetch(32'd196);
    begin
      int hits;
      hits = 0;
      bus.start      = 1'b1;
      bus.start_addr = 32'd192;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (bus.exec_done) hits++;
      end
      chk("spin_no_done", hits, 0);
    end
    // Reset mid-run aborts cleanly.
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ce", {31'd0, bus.mem_ce}, 32'd0);
    chk("abort_done", {31'd0, bus.exec_done}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
`endif

    // Illegal encodings behave as HALT.
    put_word(10'd160, enc(4'd3, 2'd0, 2'd0, 2'd3, 16'h0000));
    put_word(10'd164, enc(4'd7, 2'd1, 2'd1, 2'd0, 16'h0004));
    exp_fetch(32'd160);
    run("illegal_wc", 32'd160, 3);
    exp_fetch(32'd164);
    run("illegal_op", 32'd164, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
